// File: rtl/mips_loader_pkg.sv
// Shared constants for the MIPS32 byte-stream program loader.
package mips_loader_pkg;

    // Loader FSM state encoding (kept as plain constants for legacy tools).
    typedef logic [3:0] state_t;

    localparam state_t IDLE = 4'd0;
    localparam state_t S_AH = 4'd1;
    localparam state_t S_AL = 4'd2;
    localparam state_t S_CH = 4'd3;
    localparam state_t S_CL = 4'd4;
    localparam state_t DATA = 4'd5;
    localparam state_t CSUM = 4'd6;
    localparam state_t RUN  = 4'd7;
    localparam state_t ERR  = 4'd8;

    // Default frame start byte.
    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    // Frame layout: HDR, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, 4*N data bytes, CSUM.
    localparam int unsigned HDR_BYTES  = 5;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CSUM_BYTES = 1;

endpackage

// File: rtl/ldr_word_pack.sv
// Packs accepted data bytes big-endian into 32-bit words.
module ldr_word_pack
    import mips_loader_pkg::*;
(
    input  logic        clk1,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  cnt_q;
    // Only the first three bytes need storing; the fourth is taken straight from din.
    logic [23:0] sr_q;

    assign word_done = shift_en && (cnt_q == 2'(WORD_BYTES - 1));
    assign word      = {sr_q, din};

    // Byte counter and shift register advance on every accepted data byte.
    always_ff @(posedge clk1) begin
        if (rst || clr) begin
            cnt_q <= 2'd0;
            sr_q  <= 24'd0;
        end else if (shift_en) begin
            cnt_q <= cnt_q + 2'd1;
            sr_q  <= {sr_q[15:0], din};
        end
    end

endmodule

// File: rtl/mips_loader.sv
// Framed byte-stream loader: writes a program image into the core memory
// port and releases the core from halt once the frame checksum verifies.
module mips_loader
    import mips_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter logic [7:0]  HDR    = HDR_DEFAULT
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_run,
    output logic [ADDR_W-1:0] boot_pc,
    output logic              err
);

    state_t              state_q;
    logic [7:0]          addr_hi_q;
    logic [ADDR_W-1:0]   start_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         cnt_q;
    logic [7:0]          csum_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;

    logic                accept;
    logic                shift_en;
    logic                word_done;
    logic [31:0]         word;
    logic [15:0]         n_words;

    // Outputs decode from registered state only; no path from in_valid.
    assign in_ready  = (state_q != RUN) && (state_q != ERR);
    assign core_run  = (state_q == RUN);
    assign err       = (state_q == ERR);
    assign boot_pc   = core_run ? start_q : '0;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign accept   = in_valid && in_ready;
    assign shift_en = accept && (state_q == DATA);
    assign n_words  = {cnt_q[15:8], in_data};

    ldr_word_pack u_pack (
        .clk1      (clk1),
        .rst       (rst),
        .clr       (state_q == IDLE),
        .shift_en  (shift_en),
        .din       (in_data),
        .word      (word),
        .word_done (word_done)
    );

    // Frame FSM, header capture, running checksum and registered write port.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_hi_q   <= 8'd0;
            start_q     <= '0;
            addr_q      <= '0;
            cnt_q       <= 16'd0;
            csum_q      <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            mem_we_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        csum_q <= 8'd0;
                        if (in_data == HDR) state_q <= S_AH;
                    end
                    S_AH: begin
                        addr_hi_q <= in_data;
                        csum_q    <= csum_q ^ in_data;
                        state_q   <= S_AL;
                    end
                    S_AL: begin
                        start_q <= ADDR_W'({addr_hi_q, in_data});
                        addr_q  <= ADDR_W'({addr_hi_q, in_data});
                        csum_q  <= csum_q ^ in_data;
                        state_q <= S_CH;
                    end
                    S_CH: begin
                        cnt_q[15:8] <= in_data;
                        csum_q      <= csum_q ^ in_data;
                        state_q     <= S_CL;
                    end
                    S_CL: begin
                        cnt_q   <= n_words;
                        csum_q  <= csum_q ^ in_data;
                        state_q <= (n_words == 16'd0) ? CSUM : DATA;
                    end
                    DATA: begin
                        csum_q <= csum_q ^ in_data;
                        if (word_done) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr_q;
                            mem_wdata_q <= word;
                            // Address wraps silently modulo 2^ADDR_W.
                            addr_q      <= addr_q + 1'b1;
                            cnt_q       <= cnt_q - 16'd1;
                            if (cnt_q == 16'd1) state_q <= CSUM;
                        end
                    end
                    CSUM: begin
                        state_q <= (in_data == csum_q) ? RUN : ERR;
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_loader.sv
// Randomised self-checking bench for mips_loader with a frame-level model.
module tb_mips_loader;

    localparam int ADDR_W = 10;

    logic              clk1 = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_run;
    logic [ADDR_W-1:0] boot_pc;
    logic              err;

    mips_loader #(.ADDR_W(ADDR_W), .HDR(8'hA5)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_run  (core_run),
        .boot_pc   (boot_pc),
        .err       (err)
    );

    always #5 clk1 = ~clk1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_wr[$];
    wr_t         cur_wr;
    logic        m_run = 1'b0;
    logic        m_err = 1'b0;
    logic [ADDR_W-1:0] m_pc = '0;
    logic [31:0] seen [1024];
    int          nwrites = 0;
    int          gap_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the frame-level model.
    always @(negedge clk1) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(!(m_run || m_err)));
            check("core_run", 32'(core_run), 32'(m_run));
            check("err", 32'(err), 32'(m_err));
            check("boot_pc", 32'(boot_pc), m_run ? 32'(m_pc) : 32'd0);
            if (exp_wr.size() > 0) begin
                cur_wr = exp_wr.pop_front();
                check("mem_we", 32'(mem_we), 32'd1);
                check("mem_addr", 32'(mem_addr), 32'(cur_wr.addr));
                check("mem_wdata", mem_wdata, cur_wr.data);
            end else begin
                check("mem_we_idle", 32'(mem_we), 32'd0);
            end
            if (mem_we) begin
                seen[mem_addr] = mem_wdata;
                nwrites++;
            end
        end
    end

    // Drives one byte (after an optional random gap) and returns once accepted.
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        if (gap_max > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk1);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        rdy = in_ready;
        @(posedge clk1);
        #1;
        if (!rdy) begin
            errors++;
            $display("FAIL send_byte: byte %0h not accepted (in_ready=0)", b);
        end
    endtask

    // Sends a full frame; stop_after >= 0 truncates after that many bytes.
    task automatic run_frame(input logic [15:0] start_full, input logic [31:0] words[$],
                             input logic [7:0] csum_delta, input int stop_after);
        logic [7:0] bytes[$];
        logic [7:0] x;
        int n;
        int last;
        logic [ADDR_W-1:0] start;
        n = words.size();
        start = start_full[ADDR_W-1:0];
        bytes.push_back(8'hA5);
        bytes.push_back(start_full[15:8]);
        bytes.push_back(start_full[7:0]);
        bytes.push_back(8'(n >> 8));
        bytes.push_back(8'(n));
        foreach (words[w]) begin
            bytes.push_back(words[w][31:24]);
            bytes.push_back(words[w][23:16]);
            bytes.push_back(words[w][15:8]);
            bytes.push_back(words[w][7:0]);
        end
        x = 8'd0;
        for (int i = 1; i < bytes.size(); i++) x ^= bytes[i];
        bytes.push_back(x ^ csum_delta);
        last = bytes.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (stop_after >= 0 && i >= stop_after) break;
            send_byte(bytes[i]);
            if (i >= 5 && i < last && ((i - 5) % 4) == 3)
                exp_wr.push_back({start + ADDR_W'((i - 5) / 4), words[(i - 5) / 4]});
            if (i == last) begin
                m_pc = start;
                if (csum_delta == 8'd0) m_run = 1'b1;
                else m_err = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk1);
        @(posedge clk1);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_core_run", 32'(core_run), 32'd0);
        check("rst_boot_pc", 32'(boot_pc), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        m_run = 1'b0;
        m_err = 1'b0;
        exp_wr.delete();
        nwrites = 0;
        rst = 1'b0;
    endtask

    // Pushes bytes into a terminal loader; the compare process must see no effect.
    task automatic poke_terminal();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (6) begin
            @(posedge clk1);
            #1;
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] rnd_start();
        return 16'($urandom_range(0, 16'hFFFF));
    endfunction

    initial begin
        logic [31:0] wq[$];
        do_reset();

        // Normal load.
        wq = '{32'h28010078, 32'h0C631800, 32'h20220000, 32'h0C631800,
               32'h2842002D, 32'h0C631800, 32'h24220001, 32'hFC000000};
        run_frame(16'h0000, wq, 8'd0, -1);
        repeat (2) @(negedge clk1);
        check("normal_nwrites", 32'(nwrites), 32'd8);
        check("normal_word2", seen[2], 32'h20220000);
        check("normal_word7", seen[7], 32'hFC000000);
        check("normal_run", 32'(core_run), 32'd1);
        check("normal_pc", 32'(boot_pc), 32'd0);
        poke_terminal();
        check("normal_after_poke", 32'(nwrites), 32'd8);

        // Leading garbage then a one-word frame at 0x078.
        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        wq = '{32'h00000055};
        run_frame(16'h0078, wq, 8'd0, -1);
        repeat (2) @(negedge clk1);
        check("garbage_nwrites", 32'(nwrites), 32'd1);
        check("garbage_word", seen[10'h078], 32'h00000055);
        check("garbage_run", 32'(core_run), 32'd1);

        // Bad checksum.
        do_reset();
        run_frame(16'h0078, wq, 8'd1, -1);
        repeat (2) @(negedge clk1);
        check("badcs_nwrites", 32'(nwrites), 32'd1);
        check("badcs_err", 32'(err), 32'd1);
        check("badcs_run", 32'(core_run), 32'd0);
        poke_terminal();
        check("badcs_ready", 32'(in_ready), 32'd0);

        // Empty frame.
        do_reset();
        wq = {};
        run_frame(16'h0010, wq, 8'd0, -1);
        repeat (2) @(negedge clk1);
        check("empty_nwrites", 32'(nwrites), 32'd0);
        check("empty_pc", 32'(boot_pc), 32'h010);
        check("empty_run", 32'(core_run), 32'd1);

        // Address wrap.
        do_reset();
        wq = '{$urandom(), $urandom()};
        run_frame(16'h03FF, wq, 8'd0, -1);
        repeat (2) @(negedge clk1);
        check("wrap_hi", seen[10'h3FF], wq[0]);
        check("wrap_lo", seen[10'h000], wq[1]);

        // Stalls on a 2-word frame.
        do_reset();
        gap_max = 3;
        wq = '{$urandom(), $urandom()};
        run_frame(rnd_start(), wq, 8'd0, -1);
        gap_max = 0;
        repeat (2) @(negedge clk1);
        check("stall_nwrites", 32'(nwrites), 32'd2);

        // Reset after 6 data bytes, then a normal frame.
        do_reset();
        wq = '{$urandom(), $urandom(), $urandom()};
        run_frame(rnd_start(), wq, 8'd0, 5 + 6);
        repeat (2) @(negedge clk1);
        check("midrst_nwrites", 32'(nwrites), 32'd1);
        do_reset();
        wq = '{$urandom(), $urandom()};
        run_frame(rnd_start(), wq, 8'd0, -1);
        repeat (2) @(negedge clk1);
        check("midrst_reload", 32'(nwrites), 32'd2);

        // Random frames with random gaps and occasional corrupt checksums.
        for (int f = 0; f < 12; f++) begin
            int n;
            do_reset();
            gap_max = $urandom_range(0, 2);
            n = $urandom_range(0, 6);
            wq = {};
            for (int k = 0; k < n; k++) wq.push_back($urandom());
            run_frame(rnd_start(), wq, ($urandom_range(0, 3) == 0) ? 8'h40 : 8'h00, -1);
            repeat (2) @(negedge clk1);
            check("rand_nwrites", 32'(nwrites), 32'(n));
        end
        gap_max = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
